// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_unit
//  Purpose  : Fetch-side initiator for the instruction memory. Owns the fetch
//             PC, captures the combinationally returned instruction word into
//             a small FIFO and presents the head entry to decode through a
//             valid/ready handshake. Redirects flush the queue.
//  Ports    : CLK, RESET             clock / synchronous active-high reset
//             imem_addr, imem_data   instruction memory address / read data
//             redirect_valid/target  taken branch or jump, new fetch address
//             id_ready, id_valid     decode handshake
//             id_inst, id_pc,
//             id_pc_plus4            head entry (zero when id_valid=0)
//             fetch_misaligned       one-cycle pulse on a misaligned redirect
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_misaligned
);

  localparam int                  c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_PTR_W:0]    c_DEPTH = (c_PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]    c_CNT_ONE = (c_PTR_W + 1)'(1);
  localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);

  logic [31:0]        r_fetch_pc;
  logic [c_PTR_W:0]   r_count;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic               r_misaligned;
  logic [31:0]        r_q_pc   [FIFO_DEPTH];
  logic [31:0]        r_q_inst [FIFO_DEPTH];

  logic               w_pop;
  logic               w_push;
  logic [31:0]        w_head_pc;
  logic [31:0]        w_head_inst;

  assign w_head_pc   = r_q_pc[r_rd_ptr];
  assign w_head_inst = r_q_inst[r_rd_ptr];

  assign id_valid    = (r_count != '0);
  assign w_pop       = id_valid & id_ready;
  // A full queue can still accept a new word when the head leaves this cycle.
  assign w_push      = ~redirect_valid & ((r_count < c_DEPTH) | w_pop);

  assign imem_addr        = r_fetch_pc;
  assign id_pc            = id_valid ? w_head_pc : 32'h0;
  assign id_inst          = id_valid ? w_head_inst : 32'h0;
  assign id_pc_plus4      = id_valid ? (w_head_pc + 32'd4) : 32'h0;
  assign fetch_misaligned = r_misaligned;

  // Control state: reset beats redirect, redirect discards any push/pop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fetch_pc   <= RESET_PC;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_misaligned <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc   <= {redirect_target[31:2], 2'b00};
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_misaligned <= (redirect_target[1:0] != 2'b00);
    end else begin
      r_misaligned <= 1'b0;
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge CLK) begin
    if (!RESET && w_push) begin
      r_q_pc[r_wr_ptr]   <= r_fetch_pc;
      r_q_inst[r_wr_ptr] <= imem_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_unit
//  Purpose  : Self-checking bench for inst_fetch_unit. A second instance with
//             RESET_PC=FFFF_FFF8 covers address wrap-around.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_unit;

  localparam int          c_DEPTH = 2;
  localparam logic [31:0] c_RPC   = 32'h0000_0000;
  localparam logic [31:0] c_RPC2  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv  = 1'b0;
  logic [31:0] rt  = 32'h0;
  logic        rdy = 1'b0;

  logic [31:0] imem_addr, imem_data, id_inst, id_pc, id_pc_plus4;
  logic        id_valid, mis;
  logic [31:0] imem_addr2, imem_data2, id_inst2, id_pc2, id_pc_plus42;
  logic        id_valid2, mis2;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: queue of fetched PCs plus the next fetch address.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 | (a >> 2);
  endfunction

  assign imem_data  = mem_word(imem_addr);
  assign imem_data2 = mem_word(imem_addr2);

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(c_RPC), .FIFO_DEPTH(c_DEPTH)) dut (
    .CLK(clk), .RESET(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(rv), .redirect_target(rt), .id_ready(rdy),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .fetch_misaligned(mis)
  );

  inst_fetch_unit #(.RESET_PC(c_RPC2), .FIFO_DEPTH(c_DEPTH)) dut2 (
    .CLK(clk), .RESET(rst), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .redirect_valid(rv), .redirect_target(rt), .id_ready(rdy),
    .id_valid(id_valid2), .id_inst(id_inst2), .id_pc(id_pc2),
    .id_pc_plus4(id_pc_plus42), .fetch_misaligned(mis2)
  );

  // Apply one cycle of inputs, advance the model by the same edge, sample #1 later.
  task automatic cyc(input logic r, input logic v, input logic [31:0] t, input logic y);
    logic do_pop;
    logic do_push;
    rst = r; rv = v; rt = t; rdy = y;
    @(posedge clk);
    if (r) begin
      m_pc = c_RPC; m_q.delete(); m_mis = 1'b0;
    end else if (v) begin
      m_q.delete();
      m_pc  = {t[31:2], 2'b00};
      m_mis = (t[1:0] != 2'b00);
    end else begin
      do_pop  = (m_q.size() != 0) && y;
      do_push = (m_q.size() < c_DEPTH) || do_pop;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
      m_mis = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] got [8];
    logic [31:0] exp [8];
    string       nm  [8];
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    got[0] = {31'h0, id_valid};  exp[0] = 32'h0;   nm[0] = "reset_valid";
    got[1] = id_pc;              exp[1] = 32'h0;   nm[1] = "reset_pc";
    got[2] = id_inst;            exp[2] = 32'h0;   nm[2] = "reset_inst";
    got[3] = id_pc_plus4;        exp[3] = 32'h0;   nm[3] = "reset_plus4";
    got[4] = imem_addr;          exp[4] = c_RPC;   nm[4] = "reset_addr";
    got[5] = {31'h0, mis};       exp[5] = 32'h0;   nm[5] = "reset_mis";
    got[6] = imem_addr2;         exp[6] = c_RPC2;  nm[6] = "reset_addr2";
    got[7] = {31'h0, id_valid2}; exp[7] = 32'h0;   nm[7] = "reset_valid2";
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", nm[i], got[i], exp[i]);
      end
    end
  endtask

  task automatic test_stream();
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== (32'hA000_0000 | 32'(k))
          || id_pc_plus4 !== 32'(4 * k + 4)) begin
        n_err++;
        $display("FAIL stream_%0d: got v=%b pc=%h inst=%h p4=%h expected v=1 pc=%h inst=%h p4=%h",
                 k, id_valid, id_pc, id_inst, id_pc_plus4, 32'(4 * k),
                 32'hA000_0000 | 32'(k), 32'(4 * k + 4));
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] ea;
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      ea = (k == 1) ? 32'h4 : 32'h8;
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_addr !== ea) begin
        n_err++;
        $display("FAIL stall_%0d: got v=%b pc=%h addr=%h expected v=1 pc=0 addr=%h",
                 k, id_valid, id_pc, imem_addr, ea);
      end
    end
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) || id_inst !== mem_word(32'(4 * k))) begin
        n_err++;
        $display("FAIL release_%0d: got v=%b pc=%h inst=%h expected pc=%h",
                 k, id_valid, id_pc, id_inst, 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect();
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h40, 1'b1);
    n_checks++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || imem_addr !== 32'h40) begin
      n_err++;
      $display("FAIL redir_bubble: got v=%b pc=%h addr=%h expected v=0 pc=0 addr=40",
               id_valid, id_pc, imem_addr);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== 32'hA000_0010) begin
      n_err++;
      $display("FAIL redir_target: got v=%b pc=%h inst=%h expected v=1 pc=40 inst=a0000010",
               id_valid, id_pc, id_inst);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h44 || id_inst !== 32'hA000_0011) begin
      n_err++;
      $display("FAIL redir_next: got v=%b pc=%h inst=%h expected v=1 pc=44 inst=a0000011",
               id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_misaligned();
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h43, 1'b1);
    n_checks++;
    if (mis !== 1'b1 || imem_addr !== 32'h40 || id_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mis_pulse: got mis=%b addr=%h v=%b expected mis=1 addr=40 v=0",
               mis, imem_addr, id_valid);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (mis !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h40) begin
      n_err++;
      $display("FAIL mis_clear: got mis=%b v=%b pc=%h expected mis=0 v=1 pc=40",
               mis, id_valid, id_pc);
    end
    cyc(1'b0, 1'b1, 32'h80, 1'b1);
    n_checks++;
    if (mis !== 1'b0 || imem_addr !== 32'h80) begin
      n_err++;
      $display("FAIL mis_aligned: got mis=%b addr=%h expected mis=0 addr=80", mis, imem_addr);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (mis !== 1'b0 || id_pc !== 32'h80) begin
      n_err++;
      $display("FAIL mis_aligned_next: got mis=%b pc=%h expected mis=0 pc=80", mis, id_pc);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h43, 1'b1);
    n_checks++;
    if (id_valid !== 1'b0 || imem_addr !== c_RPC || mis !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got v=%b addr=%h mis=%b expected v=0 addr=%h mis=0",
               id_valid, imem_addr, mis, c_RPC);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (id_valid !== 1'b1 || id_pc !== c_RPC) begin
      n_err++;
      $display("FAIL reset_mid_restart: got v=%b pc=%h expected v=1 pc=%h",
               id_valid, id_pc, c_RPC);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] epc;
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      epc = c_RPC2 + 32'(4 * k);
      n_checks++;
      if (id_valid2 !== 1'b1 || id_pc2 !== epc || id_pc_plus42 !== epc + 32'd4
          || id_inst2 !== mem_word(epc)) begin
        n_err++;
        $display("FAIL wrap_%0d: got v=%b pc=%h p4=%h inst=%h expected pc=%h p4=%h inst=%h",
                 k, id_valid2, id_pc2, id_pc_plus42, id_inst2, epc, epc + 32'd4, mem_word(epc));
      end
    end
  endtask

  task automatic test_random();
    logic        r, v, y;
    logic [31:0] t, epc, ep4, einst;
    logic        ev;
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) == 0);
      t = $urandom;
      y = ($urandom_range(0, 99) < 60);
      cyc(r, v, t, y);
      ev    = (m_q.size() != 0);
      epc   = ev ? m_q[0] : 32'h0;
      ep4   = ev ? m_q[0] + 32'd4 : 32'h0;
      einst = ev ? mem_word(m_q[0]) : 32'h0;
      n_checks++;
      if (id_valid !== ev || id_pc !== epc || id_pc_plus4 !== ep4 || id_inst !== einst
          || imem_addr !== m_pc || mis !== m_mis) begin
        n_err++;
        $display("FAIL random_%0d: got v=%b pc=%h p4=%h inst=%h addr=%h mis=%b expected v=%b pc=%h p4=%h inst=%h addr=%h mis=%b",
                 n, id_valid, id_pc, id_pc_plus4, id_inst, imem_addr, mis,
                 ev, epc, ep4, einst, m_pc, m_mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
